outerprodrc_ctl: RTL and testbench

- Parametrised successor of the rate-coded uGEMM outer-product array.
- On each start it captures sign-magnitude row/column vectors and runs one full unary rate-coded period on its own.
- Each period accumulates signed products into per-cell two's-complement counters, so K-dimension partial outer products can be summed across consecutive runs.
- Sits between the operand buffers and the output writeback of the unary GEMM tile.

---
 rtl/outerprodrc_pkg.sv | 20 ++
 rtl/outerprodrc_cell.sv | 46 ++++
 rtl/sobolrng.sv | 36 +++
 rtl/outerprodrc_ctl.sv | 129 ++++++++++++
 tb/tb_outerprodrc_ctl.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/outerprodrc_pkg.sv
// Shared defaults, FSM encoding and run-length helper for the
// rate-coded outer-product controller.
package outerprodrc_pkg;

  localparam int ROWNUM_DEF      = 4;
  localparam int COLNUM_DEF      = 4;
  localparam int BITWIDTH_DEF    = 8;
  localparam int OUTBITWIDTH_DEF = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic int run_len(int bw);
    return 1 << (bw - 1);
  endfunction

  localparam int RUNLEN = run_len(BITWIDTH_DEF);

endpackage

// File: rtl/outerprodrc_cell.sv
// Signed per-cell up/down accumulator.
// Define OUTERPRODRC_SAT_EN to clamp at +/-(2^(OW-1)-1).
module outerprodrc_cell #(
  parameter int OW = 16
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iClr,
  input  logic          iInc,
  input  logic          iDec,
  output logic [OW-1:0] oAcc
);

  logic [OW-1:0] acc_q, acc_d;
  logic          at_pos, at_neg;

`ifdef OUTERPRODRC_SAT_EN
  localparam logic [OW-1:0] POS_LIM = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] NEG_LIM = ~POS_LIM + OW'(1);
  assign at_pos = (acc_q == POS_LIM);
  assign at_neg = (acc_q == NEG_LIM);
`else
  assign at_pos = 1'b0;
  assign at_neg = 1'b0;
`endif

  always_comb begin
    acc_d = acc_q;
    if (iClr)
      acc_d = '0;
    else if (iInc && !at_pos)
      acc_d = acc_q + OW'(1);
    else if (iDec && !at_neg)
      acc_d = acc_q - OW'(1);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)
      acc_q <= '0;
    else
      acc_q <= acc_d;
  end

  assign oAcc = acc_q;

endmodule

// File: rtl/sobolrng.sv
// First-dimension Sobol source: bit-reversed step counter,
// giving 0, 1/2, 1/4, 3/4, ... of full scale.
module sobolrng #(
  parameter int RWID = 7
) (
  input  logic            iClk,
  input  logic            iRstN,
  input  logic            iEn,
  input  logic            iClr,
  output logic [RWID-1:0] oOut
);

  logic [RWID-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (iClr)
      cnt_d = '0;
    else if (iEn)
      cnt_d = cnt_q + RWID'(1);
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  always_comb begin
    oOut = '0;
    for (int b = 0; b < RWID; b++)
      oOut[b] = cnt_q[RWID-1-b];
  end

endmodule

// File: rtl/outerprodrc_ctl.sv
// Rate-coded unary outer-product array with run FSM.
// Optional saturation: define OUTERPRODRC_SAT_EN.
module outerprodrc_ctl
  import outerprodrc_pkg::*;
#(
  parameter int ROWNUM      = ROWNUM_DEF,
  parameter int COLNUM      = COLNUM_DEF,
  parameter int BITWIDTH    = BITWIDTH_DEF,
  parameter int OUTBITWIDTH = OUTBITWIDTH_DEF
) (
  input  logic                                 iClk,
  input  logic                                 iRst,
  input  logic                                 iEn,
  input  logic                                 iClr,
  input  logic                                 iStart,
  input  logic                                 iAccum,
  input  logic [ROWNUM*BITWIDTH-1:0]           iData0,
  input  logic [COLNUM*BITWIDTH-1:0]           iData1,
  output logic                                 oBusy,
  output logic                                 oDone,
  output logic [ROWNUM*COLNUM*OUTBITWIDTH-1:0] oData
);

  localparam int MW = BITWIDTH - 1;
  localparam logic [BITWIDTH-1:0] LAST =
    BITWIDTH'(run_len(BITWIDTH) - 1);

  logic [1:0]                 state_q, state_d;
  logic [BITWIDTH-1:0]        cnt_q, cnt_d;
  logic [ROWNUM*BITWIDTH-1:0] op0_q, op0_d;
  logic [COLNUM*BITWIDTH-1:0] op1_q, op1_d;
  logic start, step, fin;
  logic rng_clr, acc_clr, rst_n;

  assign rst_n   = ~iRst;
  assign start   = (state_q == S_IDLE) && iStart && !iClr;
  assign step    = (state_q == S_RUN) && iEn && !iClr;
  assign fin     = (state_q == S_DONE) && !iClr;
  assign rng_clr = iClr | start;
  assign acc_clr = iClr | (start & ~iAccum);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op0_d   = op0_q;
    op1_d   = op1_q;
    unique case (1'b1)
      iClr: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      start: begin
        state_d = S_RUN;
        cnt_d   = '0;
        op0_d   = iData0;
        op1_d   = iData1;
      end
      step: begin
        cnt_d = cnt_q + BITWIDTH'(1);
        if (cnt_q == LAST)
          state_d = S_DONE;
      end
      fin: state_d = S_IDLE;
      default: ;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op0_q   <= '0;
      op1_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op0_q   <= op0_d;
      op1_q   <= op1_d;
    end
  end

  assign oBusy = (state_q == S_RUN);
  assign oDone = (state_q == S_DONE);

  for (genvar i = 0; i < ROWNUM; i++) begin : g_row
    logic [MW-1:0] mag0, ctl_val, col_val;
    logic          sgn0, row_bit;

    assign mag0    = op0_q[i*BITWIDTH +: MW];
    assign sgn0    = op0_q[i*BITWIDTH + MW];
    assign row_bit = mag0 > ctl_val;

    sobolrng #(.RWID(MW)) u_ctl_rng (
      .iClk  (iClk),
      .iRstN (rst_n),
      .iEn   (step),
      .iClr  (rng_clr),
      .oOut  (ctl_val)
    );

    // Column stream only advances on row ones, decorrelating the pair.
    sobolrng #(.RWID(MW)) u_col_rng (
      .iClk  (iClk),
      .iRstN (rst_n),
      .iEn   (step & row_bit),
      .iClr  (rng_clr),
      .oOut  (col_val)
    );

    for (genvar j = 0; j < COLNUM; j++) begin : g_col
      logic [MW-1:0] mag1;
      logic          prod, neg;

      assign mag1 = op1_q[j*BITWIDTH +: MW];
      assign prod = step & row_bit & (mag1 > col_val);
      assign neg  = sgn0 ^ op1_q[j*BITWIDTH + MW];

      outerprodrc_cell #(.OW(OUTBITWIDTH)) u_cell (
        .iClk (iClk),
        .iRst (iRst),
        .iClr (acc_clr),
        .iInc (prod & ~neg),
        .iDec (prod & neg),
        .oAcc (oData[(i*COLNUM+j)*OUTBITWIDTH +: OUTBITWIDTH])
      );
    end
  end

endmodule

// File: tb/tb_outerprodrc_ctl.sv
// Scoreboard bench for outerprodrc_ctl: 4x4, 4-bit operands,
// one 9-bit and one 5-bit accumulator instance on shared inputs.
module tb_outerprodrc_ctl;

  localparam int RN  = 4;
  localparam int CN  = 4;
  localparam int BW  = 4;
  localparam int OWA = 9;
  localparam int OWB = 5;
  localparam int NC  = RN * CN;

  logic iClk = 1'b0;
  logic iRst, iEn, iClr, iStart, iAccum;
  logic [RN*BW-1:0] iData0;
  logic [CN*BW-1:0] iData1;
  logic busy_a, done_a, busy_b, done_b;
  logic [NC*OWA-1:0] data_a;
  logic [NC*OWB-1:0] data_b;

  int checks   = 0;
  int failures = 0;
  int acc_a[NC];
  int acc_b[NC];

  typedef struct {
    logic [NC*OWA-1:0] a;
    logic [NC*OWB-1:0] b;
    int                lat;
  } exp_t;
  exp_t sb[$];

  // First-dimension Sobol values at 3 bits, in sequence order.
  int vdc[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  always #5 iClk = ~iClk;

  outerprodrc_ctl #(
    .ROWNUM(RN), .COLNUM(CN), .BITWIDTH(BW), .OUTBITWIDTH(OWA)
  ) dut_a (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr),
    .iStart(iStart), .iAccum(iAccum),
    .iData0(iData0), .iData1(iData1),
    .oBusy(busy_a), .oDone(done_a), .oData(data_a)
  );

  outerprodrc_ctl #(
    .ROWNUM(RN), .COLNUM(CN), .BITWIDTH(BW), .OUTBITWIDTH(OWB)
  ) dut_b (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr),
    .iStart(iStart), .iAccum(iAccum),
    .iData0(iData0), .iData1(iData1),
    .oBusy(busy_b), .oDone(done_b), .oData(data_b)
  );

  function automatic logic [3:0] sm(int v);
    if (v < 0) return {1'b1, 3'(-v)};
    return {1'b0, 3'(v)};
  endfunction

  // Row m0 ones drive m0 column draws; count draws below m1.
  function automatic int pcount(int m0, int m1);
    int n = 0;
    for (int k = 0; k < m0; k++)
      if (vdc[k] < m1) n++;
    return n;
  endfunction

  function automatic int clampb(int v);
`ifdef OUTERPRODRC_SAT_EN
    if (v > 15) return 15;
    if (v < -15) return -15;
`endif
    return v;
  endfunction

  task automatic model_push(input logic [15:0] d0, input logic [15:0] d1,
                            input logic accum, input int lat);
    exp_t e;
    int idx, dl;
    for (int i = 0; i < RN; i++)
      for (int j = 0; j < CN; j++) begin
        idx = i * CN + j;
        dl = pcount(int'(d0[i*BW +: 3]), int'(d1[j*BW +: 3]));
        if (d0[i*BW+3] ^ d1[j*BW+3]) dl = -dl;
        if (!accum) begin
          acc_a[idx] = 0;
          acc_b[idx] = 0;
        end
        acc_a[idx] = acc_a[idx] + dl;
        acc_b[idx] = clampb(acc_b[idx] + dl);
        e.a[idx*OWA +: OWA] = OWA'(acc_a[idx]);
        e.b[idx*OWB +: OWB] = OWB'(acc_b[idx]);
      end
    e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic model_zero();
    for (int k = 0; k < NC; k++) begin
      acc_a[k] = 0;
      acc_b[k] = 0;
    end
  endtask

  // Starts a run, optionally stalls iEn or pokes iStart mid-run,
  // then pops the scoreboard at oDone.
  task automatic run_op(input logic [15:0] d0, input logic [15:0] d1,
                        input logic accum, input int stall_at,
                        input int stall_len, input int poke_at);
    exp_t e;
    int c;
    bit seen;
    @(negedge iClk);
    iData0 = d0; iData1 = d1; iAccum = accum;
    iStart = 1'b1; iEn = 1'b1;
    model_push(d0, d1, accum, 9 + stall_len);
    @(negedge iClk);
    iStart = 1'b0;
    iData0 = 16'($urandom);
    iData1 = 16'($urandom);
    iAccum = 1'($urandom);
    c = 1;
    seen = 0;
    while (!seen && c <= 40) begin
      if (done_a) begin
        seen = 1;
        e = sb.pop_front();
        checks++;
        if (c !== e.lat) begin
          failures++;
          $display("FAIL done_latency: got %0d want %0d", c, e.lat);
        end
        checks++;
        if (data_a !== e.a) begin
          failures++;
          $display("FAIL data_a: got %h want %h", data_a, e.a);
        end
        checks++;
        if (data_b !== e.b) begin
          failures++;
          $display("FAIL data_b: got %h want %h", data_b, e.b);
        end
        checks++;
        if (done_b !== 1'b1 || busy_a !== 1'b0) begin
          failures++;
          $display("FAIL done_state: done_b=%b busy_a=%b want 1 0",
                   done_b, busy_a);
        end
      end else begin
        if (c == 2) begin
          checks++;
          if (busy_a !== 1'b1) begin
            failures++;
            $display("FAIL busy_in_run: got %b want 1", busy_a);
          end
        end
        iEn = !(c >= stall_at && c < stall_at + stall_len);
        iStart = (c == poke_at);
        @(negedge iClk);
        c++;
      end
    end
    iEn = 1'b1;
    iStart = 1'b0;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no oDone want oDone");
      void'(sb.pop_front());
    end
  endtask

  task automatic test_reset();
    iRst = 1'b1;
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b%b want 00", busy_a, busy_b);
    end
    checks++;
    if (done_a !== 1'b0 || done_b !== 1'b0) begin
      failures++;
      $display("FAIL reset_done: got %b%b want 00", done_a, done_b);
    end
    checks++;
    if (data_a !== '0) begin
      failures++;
      $display("FAIL reset_data_a: got %h want 0", data_a);
    end
    checks++;
    if (data_b !== '0) begin
      failures++;
      $display("FAIL reset_data_b: got %h want 0", data_b);
    end
    iRst = 1'b0;
    model_zero();
  endtask

  task automatic test_basic();
    run_op({12'h0, sm(4)}, {12'h0, sm(4)}, 1'b0, 0, 0, 0);
    checks++;
    if (data_a[8:0] !== 9'd2) begin
      failures++;
      $display("FAIL basic_cell00: got %0d want 2", $signed(data_a[8:0]));
    end
  endtask

  task automatic test_sign();
    run_op({4'b1000, sm(3), 4'b1000, sm(4)},
           {sm(5), 4'b1000, sm(-2), sm(-4)}, 1'b0, 0, 0, 0);
    checks++;
    if (data_a[8:0] !== 9'h1FE) begin
      failures++;
      $display("FAIL sign_cell00: got %0d want -2", $signed(data_a[8:0]));
    end
    checks++;
    if (data_a[4*OWA +: OWA] !== 9'd0 || data_a[2*OWA +: OWA] !== 9'd0) begin
      failures++;
      $display("FAIL neg_zero: got %h %h want 0 0",
               data_a[4*OWA +: OWA], data_a[2*OWA +: OWA]);
    end
  endtask

  task automatic test_accum();
    run_op({12'h0, sm(4)}, {12'h0, sm(-4)}, 1'b0, 0, 0, 0);
    run_op({12'h0, sm(4)}, {12'h0, sm(-4)}, 1'b1, 0, 0, 0);
    checks++;
    if (data_a[8:0] !== 9'h1FC) begin
      failures++;
      $display("FAIL accum_sum: got %0d want -4", $signed(data_a[8:0]));
    end
    run_op({12'h0, sm(4)}, {12'h0, sm(-4)}, 1'b0, 0, 0, 0);
    checks++;
    if (data_a[8:0] !== 9'h1FE) begin
      failures++;
      $display("FAIL accum_restart: got %0d want -2", $signed(data_a[8:0]));
    end
  endtask

  task automatic test_stall();
    run_op({12'h0, sm(4)}, {12'h0, sm(4)}, 1'b0, 3, 5, 0);
    checks++;
    if (data_a[8:0] !== 9'd2) begin
      failures++;
      $display("FAIL stall_cell00: got %0d want 2", $signed(data_a[8:0]));
    end
  endtask

  task automatic test_start_ignored();
    int hits = 0;
    run_op({12'h0, sm(4)}, {12'h0, sm(4)}, 1'b0, 0, 0, 3);
    repeat (12) begin
      @(negedge iClk);
      if (done_a || busy_a) hits++;
    end
    checks++;
    if (hits != 0) begin
      failures++;
      $display("FAIL start_ignored: extra activity %0d want 0", hits);
    end
  endtask

  task automatic test_clear();
    int hits = 0;
    @(negedge iClk);
    iData0 = {12'h0, sm(4)}; iData1 = {12'h0, sm(4)};
    iAccum = 1'b1; iStart = 1'b1; iEn = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    repeat (2) @(negedge iClk);
    iClr = 1'b1;
    @(negedge iClk);
    iClr = 1'b0;
    model_zero();
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      failures++;
      $display("FAIL clear_state: busy=%b done=%b want 0 0", busy_a, done_a);
    end
    checks++;
    if (data_a !== '0 || data_b !== '0) begin
      failures++;
      $display("FAIL clear_data: got %h %h want 0", data_a, data_b);
    end
    repeat (15) begin
      @(negedge iClk);
      if (done_a || busy_a) hits++;
    end
    checks++;
    if (hits != 0) begin
      failures++;
      $display("FAIL clear_no_done: activity %0d want 0", hits);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++)
      run_op(16'($urandom), 16'($urandom),
             (r == 0) ? 1'b0 : 1'($urandom), 0, 0, 0);
  endtask

  task automatic test_sat();
    logic [4:0] want_b;
`ifdef OUTERPRODRC_SAT_EN
    want_b = 5'b01111;
`else
    want_b = 5'b10001;
`endif
    for (int r = 0; r < 7; r++)
      run_op({12'h0, sm(7)}, {12'h0, sm(7)}, (r != 0), 0, 0, 0);
    checks++;
    if (data_b[4:0] !== want_b) begin
      failures++;
      $display("FAIL overflow_cell00: got %0d want %0d",
               $signed(data_b[4:0]), $signed(want_b));
    end
    checks++;
    if (data_a[8:0] !== 9'd49) begin
      failures++;
      $display("FAIL wide_cell00: got %0d want 49", $signed(data_a[8:0]));
    end
  endtask

  task automatic test_async_reset();
    int hits = 0;
    @(negedge iClk);
    iData0 = {12'h0, sm(5)}; iData1 = {12'h0, sm(6)};
    iAccum = 1'b1; iStart = 1'b1; iEn = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    repeat (3) @(negedge iClk);
    #2 iRst = 1'b1;
    #1;
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || busy_b !== 1'b0) begin
      failures++;
      $display("FAIL async_state: busy=%b done=%b want 0 0", busy_a, done_a);
    end
    checks++;
    if (data_a !== '0 || data_b !== '0) begin
      failures++;
      $display("FAIL async_data: got %h %h want 0", data_a, data_b);
    end
    @(negedge iClk);
    iRst = 1'b0;
    model_zero();
    repeat (12) begin
      @(negedge iClk);
      if (done_a || busy_a) hits++;
    end
    checks++;
    if (hits != 0) begin
      failures++;
      $display("FAIL async_no_done: activity %0d want 0", hits);
    end
    run_op({12'h0, sm(4)}, {12'h0, sm(4)}, 1'b0, 0, 0, 0);
  endtask

  initial begin
    iRst = 1'b0; iEn = 1'b1; iClr = 1'b0; iStart = 1'b0;
    iAccum = 1'b0; iData0 = '0; iData1 = '0;
    model_zero();
    test_reset();
    test_basic();
    test_sign();
    test_accum();
    test_stall();
    test_start_ignored();
    test_clear();
    test_random();
    test_sat();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
